// File: rtl/alu_arb.sv
// Round-robin arbiter that shares one combinational ALU between two requesters
// and returns each registered result on a single ID-tagged response channel.
module alu_arb #(
  parameter int BW_DATA = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [BW_DATA-1:0] i_req0_a,
  input  logic [BW_DATA-1:0] i_req0_b,
  input  logic [2:0]         i_req0_f,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [BW_DATA-1:0] i_req1_a,
  input  logic [BW_DATA-1:0] i_req1_b,
  input  logic [2:0]         i_req1_f,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [BW_DATA-1:0] o_rsp_y,
  output logic               o_rsp_cout,
  output logic               o_rsp_id,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic               ptr;
  logic               grant_id;
  logic               accept;
  logic [BW_DATA-1:0] op_a, op_b;
  logic [2:0]         op_f;
  logic               op_id;
  logic [BW_DATA-1:0] alu_y;
  logic               alu_cout;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Ready is granted only in IDLE and only to the winner, so a handshake is
  // implied whenever any request is valid there.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    grant_id     = ptr;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (i_req0_valid && !i_req1_valid)      grant_id = 1'b0;
        else if (i_req1_valid && !i_req0_valid) grant_id = 1'b1;
        if (i_req0_valid || i_req1_valid) begin
          accept       = 1'b1;
          o_req0_ready = !grant_id;
          o_req1_ready = grant_id;
          state_nxt    = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr         <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_f        <= '0;
      op_id       <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_y     <= '0;
      o_rsp_cout  <= 1'b0;
    end else begin
      if (accept) begin
        op_a  <= grant_id ? i_req1_a : i_req0_a;
        op_b  <= grant_id ? i_req1_b : i_req0_b;
        op_f  <= grant_id ? i_req1_f : i_req0_f;
        op_id <= grant_id;
        ptr   <= !grant_id;
      end
      if (state == EXEC) begin
        o_rsp_y     <= alu_y;
        o_rsp_cout  <= alu_cout;
        o_rsp_valid <= 1'b1;
      end else if (state == RESP && i_rsp_ready) begin
        o_rsp_valid <= 1'b0;
      end
    end
  end

  assign o_rsp_id = op_id;
  assign o_busy   = (state != IDLE);

  alu_arb_alu #(.BW_DATA(BW_DATA)) u_alu (
    .a    (op_a),
    .b    (op_b),
    .f    (op_f),
    .y    (alu_y),
    .cout (alu_cout)
  );

endmodule

// Combinational 8-op ALU; carry is produced only by the add function.
module alu_arb_alu #(
  parameter int BW_DATA = 4
) (
  input  logic [BW_DATA-1:0] a,
  input  logic [BW_DATA-1:0] b,
  input  logic [2:0]         f,
  output logic [BW_DATA-1:0] y,
  output logic               cout
);

  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (f)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: {cout, y} = {1'b0, a} + {1'b0, b};
      3'b011: y = '0;
      3'b100: y = a & ~b;
      3'b101: y = a | ~b;
      3'b110: y = a - b;
      3'b111: y[0] = (a < b);
      default: y = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: directed scenarios plus a response scoreboard.
module tb_alu_arb;

  localparam int BW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req0_valid, i_req1_valid;
  logic          o_req0_ready, o_req1_ready;
  logic [BW-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [2:0]    i_req0_f, i_req1_f;
  logic          o_rsp_valid, i_rsp_ready;
  logic [BW-1:0] o_rsp_y;
  logic          o_rsp_cout, o_rsp_id, o_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int y;
    int cout;
    int id;
  } rsp_t;

  rsp_t sb[$];

  alu_arb #(.BW_DATA(BW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .i_req0_f     (i_req0_f),
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .i_req1_f     (i_req1_f),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_y      (o_rsp_y),
    .o_rsp_cout   (o_rsp_cout),
    .o_rsp_id     (o_rsp_id),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic rsp_t model(input int a, input int b, input int f, input int id);
    rsp_t r;
    r.cout = 0;
    r.id   = id;
    case (f)
      0: r.y = a & b;
      1: r.y = a | b;
      2: begin r.y = (a + b) % 16; r.cout = (a + b) / 16; end
      3: r.y = 0;
      4: r.y = a & (15 - b);
      5: r.y = a | (15 - b);
      6: r.y = (a - b + 16) % 16;
      default: r.y = (a < b) ? 1 : 0;
    endcase
    return r;
  endfunction

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
    end else begin
      if (o_rsp_valid && i_rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", 1, 0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          check("sb_y", int'(o_rsp_y), e.y);
          check("sb_cout", int'(o_rsp_cout), e.cout);
          check("sb_id", int'(o_rsp_id), e.id);
        end
      end
      if (o_req0_ready && o_req1_ready) check("dual_ready", 1, 0);
      if (o_req0_ready && i_req0_valid)
        sb.push_back(model(int'(i_req0_a), int'(i_req0_b), int'(i_req0_f), 0));
      if (o_req1_ready && i_req1_valid)
        sb.push_back(model(int'(i_req1_a), int'(i_req1_b), int'(i_req1_f), 1));
    end
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(o_rsp_valid), 0);
    check({tag, "_y"}, int'(o_rsp_y), 0);
    check({tag, "_cout"}, int'(o_rsp_cout), 0);
    check({tag, "_id"}, int'(o_rsp_id), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
  endtask

  // Issue one op on requester id, wait for its response and check it.
  // Called and returns at #1 after a rising edge.
  task automatic do_op(input int id, input int a, input int b, input int f,
                       input int ey, input int ec, output int waits);
    int n;
    logic rdy;
    waits = 0;
    if (id == 0) begin
      i_req0_valid = 1'b1; i_req0_a = BW'(a); i_req0_b = BW'(b); i_req0_f = 3'(f);
    end else begin
      i_req1_valid = 1'b1; i_req1_a = BW'(a); i_req1_b = BW'(b); i_req1_f = 3'(f);
    end
    rdy = 1'b0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge i_clk);
      rdy = (id == 0) ? o_req0_ready : o_req1_ready;
      if (!rdy) begin waits++; next_cycle(); end
    end
    if (!rdy) begin check("req_timeout", 0, 1); return; end
    next_cycle();
    // Disturb inputs after acceptance; the in-flight op must not notice.
    if (id == 0) begin
      i_req0_valid = 1'b0; i_req0_a = 4'd7; i_req0_b = BW'($urandom);
    end else begin
      i_req1_valid = 1'b0; i_req1_a = 4'd7; i_req1_b = BW'($urandom);
    end
    n = 0;
    @(negedge i_clk);
    while (!o_rsp_valid && n < 20) begin
      n++;
      @(negedge i_clk);
    end
    check("rsp_latency", n, 1);
    check("op_y", int'(o_rsp_y), ey);
    check("op_cout", int'(o_rsp_cout), ec);
    check("op_id", int'(o_rsp_id), id);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int gid[$];
    int gcyc[$];

    i_req0_a = '0; i_req0_b = '0; i_req0_f = '0;
    i_req1_a = '0; i_req1_b = '0; i_req1_f = '0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_rsp_ready = 1'b1;

    // Reset values
    i_rst = 1'b1;
    next_cycle();
    @(negedge i_clk);
    check_reset_outputs("rst");
    next_cycle();
    i_rst = 1'b0;

    // Add with carry, latency and busy
    i_req0_valid = 1'b1; i_req0_a = 4'd9; i_req0_b = 4'd8; i_req0_f = 3'b010;
    @(negedge i_clk);
    check("t1_ready0", int'(o_req0_ready), 1);
    check("t1_ready1", int'(o_req1_ready), 0);
    check("t1_busy_T", int'(o_busy), 0);
    next_cycle();
    i_req0_valid = 1'b0;
    @(negedge i_clk);
    check("t1_busy_T1", int'(o_busy), 1);
    check("t1_valid_T1", int'(o_rsp_valid), 0);
    next_cycle();
    @(negedge i_clk);
    check("t1_valid_T2", int'(o_rsp_valid), 1);
    check("t1_busy_T2", int'(o_busy), 1);
    check("t1_y", int'(o_rsp_y), 1);
    check("t1_cout", int'(o_rsp_cout), 1);
    check("t1_id", int'(o_rsp_id), 0);
    next_cycle();
    @(negedge i_clk);
    check("t1_valid_after", int'(o_rsp_valid), 0);
    check("t1_busy_after", int'(o_busy), 0);
    next_cycle();

    // Both requesters always valid: round-robin alternation
    apply_reset();
    i_req0_valid = 1'b1; i_req0_a = 4'd12; i_req0_b = 4'd10; i_req0_f = 3'b000;
    i_req1_valid = 1'b1; i_req1_a = 4'd3;  i_req1_b = 4'd4;  i_req1_f = 3'b001;
    for (int c = 0; c < 12; c++) begin
      @(negedge i_clk);
      if (o_req0_ready) begin gid.push_back(0); gcyc.push_back(c); end
      if (o_req1_ready) begin gid.push_back(1); gcyc.push_back(c); end
      next_cycle();
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    check("rr_count", gid.size(), 4);
    for (int k = 0; k < 4 && k < gid.size(); k++) begin
      check("rr_id", gid[k], k % 2);
      check("rr_cycle", gcyc[k], 3 * k);
    end
    repeat (3) next_cycle();

    // Backpressure hold with pending req0
    apply_reset();
    i_rsp_ready = 1'b0;
    i_req1_valid = 1'b1; i_req1_a = 4'd2; i_req1_b = 4'd5; i_req1_f = 3'b110;
    @(negedge i_clk);
    check("bp_ready1", int'(o_req1_ready), 1);
    next_cycle();
    i_req1_valid = 1'b0;
    i_req0_valid = 1'b1; i_req0_a = 4'd3; i_req0_b = 4'd5; i_req0_f = 3'b111;
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      check("bp_valid", int'(o_rsp_valid), 1);
      check("bp_y", int'(o_rsp_y), 13);
      check("bp_cout", int'(o_rsp_cout), 0);
      check("bp_id", int'(o_rsp_id), 1);
      check("bp_ready0", int'(o_req0_ready), 0);
      next_cycle();
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    check("bp_hs_valid", int'(o_rsp_valid), 1);
    check("bp_hs_ready0", int'(o_req0_ready), 0);
    next_cycle();
    do_op(0, 3, 5, 7, 1, 0, w);
    check("bp_next_wait", w, 0);

    // Compare / zero
    do_op(0, 5, 3, 7, 0, 0, w);
    do_op(0, 15, 15, 3, 0, 0, w);
    // Remaining functions through requester 1
    do_op(1, 12, 10, 4, 4, 0, w);
    do_op(1, 8, 6, 5, 9, 0, w);
    do_op(1, 7, 9, 2, 0, 1, w);

    // Reset during EXEC
    apply_reset();
    i_req0_valid = 1'b1; i_req0_a = 4'd6; i_req0_b = 4'd3; i_req0_f = 3'b010;
    @(negedge i_clk);
    check("rx_ready0", int'(o_req0_ready), 1);
    next_cycle();
    i_req0_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rx_busy_exec", int'(o_busy), 1);
    next_cycle();
    i_rst = 1'b0;
    @(negedge i_clk);
    check_reset_outputs("rx");
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge i_clk);
      check("rx_no_rsp", int'(o_rsp_valid), 0);
    end
    next_cycle();
    i_req0_valid = 1'b1; i_req0_a = 4'd5; i_req0_b = 4'd10; i_req0_f = 3'b001;
    i_req1_valid = 1'b1; i_req1_a = 4'd1; i_req1_b = 4'd1; i_req1_f = 3'b010;
    @(negedge i_clk);
    check("rx_ptr_ready0", int'(o_req0_ready), 1);
    check("rx_ptr_ready1", int'(o_req1_ready), 0);
    next_cycle();
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    repeat (3) next_cycle();

    // Operand change after acceptance (do_op sets A=7 at T+1)
    do_op(0, 1, 1, 2, 2, 0, w);

    repeat (2) next_cycle();
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
